// File: rtl/multi_rate_divider.sv
// Multi-channel tick generator: each channel counts down from its period, ticks at zero.
// Ports: clk, resetn, run, ch_en, restart, wr_* period/mode write, tick/busy per channel.
module multi_rate_divider #(
  parameter int WIDTH = 28,
  parameter int NUM_CH = 4,
  parameter int CH_BITS = 2,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(12499999)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  input  logic [NUM_CH-1:0]  ch_en,
  input  logic [NUM_CH-1:0]  restart,
  input  logic               wr_en,
  input  logic [CH_BITS-1:0] wr_ch,
  input  logic [WIDTH-1:0]   wr_period,
  input  logic               wr_oneshot,
  output logic [NUM_CH-1:0]  tick,
  output logic [NUM_CH-1:0]  busy
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] load;
    logic             oneshot;
    logic             armed;
    logic             tick_q;
    logic             hit;

    // out-of-range wr_ch never matches any channel
    assign hit  = wr_en && (wr_ch == CH_BITS'(i));
    // a write in the restart cycle takes effect for that reload
    assign load = hit ? wr_period : period;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        period  <= DEFAULT_PERIOD;
        oneshot <= 1'b0;
        count   <= DEFAULT_PERIOD;
        armed   <= 1'b1;
        tick_q  <= 1'b0;
      end else begin
        if (hit) begin
          period  <= wr_period;
          oneshot <= wr_oneshot;
        end
        if (restart[i]) begin
          count  <= load;
          armed  <= 1'b1;
          tick_q <= 1'b0;
        end else if (!armed || !run || !ch_en[i]) begin
          tick_q <= 1'b0;
        end else if (count == '0) begin
          tick_q <= 1'b1;
          if (oneshot) begin
            armed <= 1'b0;
          end else begin
            count <= period;
          end
        end else begin
          count  <= count - WIDTH'(1);
          tick_q <= 1'b0;
        end
      end
    end

    assign tick[i] = tick_q;
    assign busy[i] = armed;
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Scoreboard bench for multi_rate_divider: directed scenarios plus random traffic.
// Expected tick/busy come from a per-channel reference model in the bench.
module tb_multi_rate_divider;
  localparam int W  = 8;
  localparam int NC = 3;
  localparam int CB = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          run = 1'b0;
  logic [NC-1:0] ch_en = '0;
  logic [NC-1:0] restart = '0;
  logic          wr_en = 1'b0;
  logic [CB-1:0] wr_ch = '0;
  logic [W-1:0]  wr_period = '0;
  logic          wr_oneshot = 1'b0;
  logic [NC-1:0] tick;
  logic [NC-1:0] busy;

  int n_chk = 0;
  int n_fail = 0;
  int edge_no = 0;

  int unsigned m_per[NC];
  int unsigned m_cnt[NC];
  bit          m_os[NC];
  bit          m_arm[NC];
  bit          m_tk[NC];

  logic [2*NC-1:0] sb_q[$];

  multi_rate_divider #(
    .WIDTH(W),
    .NUM_CH(NC),
    .CH_BITS(CB),
    .DEFAULT_PERIOD(8'd3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .run(run),
    .ch_en(ch_en),
    .restart(restart),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_period(wr_period),
    .wr_oneshot(wr_oneshot),
    .tick(tick),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_per[i] = 3;
      m_cnt[i] = 3;
      m_os[i]  = 0;
      m_arm[i] = 1;
      m_tk[i]  = 0;
    end
  endtask

  task automatic model_step();
    logic [2*NC-1:0] e;
    for (int i = 0; i < NC; i++) begin
      bit hit;
      int unsigned p;
      hit = wr_en && (int'(wr_ch) == i);
      p = hit ? int'(wr_period) : m_per[i];
      if (restart[i]) begin
        m_cnt[i] = p;
        m_arm[i] = 1;
        m_tk[i]  = 0;
      end else if (!m_arm[i] || !run || !ch_en[i]) begin
        m_tk[i] = 0;
      end else if (m_cnt[i] == 0) begin
        m_tk[i] = 1;
        if (m_os[i]) m_arm[i] = 0;
        else m_cnt[i] = m_per[i];
      end else begin
        m_cnt[i] = m_cnt[i] - 1;
        m_tk[i]  = 0;
      end
      if (hit) begin
        m_per[i] = wr_period;
        m_os[i]  = wr_oneshot;
      end
    end
    for (int i = 0; i < NC; i++) begin
      e[NC+i] = m_tk[i];
      e[i]    = m_arm[i];
    end
    sb_q.push_back(e);
  endtask

  // Commit one clock edge with the inputs currently applied (called at negedge).
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    restart = '0;
    wr_en = 1'b0;
  endtask

  task automatic wr(input int ch, input int per, input bit os);
    wr_en = 1'b1;
    wr_ch = CB'(ch);
    wr_period = W'(per);
    wr_oneshot = os;
  endtask

  // Monitor: every committed edge has exactly one expected entry queued.
  always @(posedge clk) begin
    logic [2*NC-1:0] e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      edge_no++;
      n_chk++;
      if (tick !== e[2*NC-1:NC]) begin
        n_fail++;
        $display("FAIL sb_tick edge %0d: got %b expected %b",
                 edge_no, tick, e[2*NC-1:NC]);
      end
      n_chk++;
      if (busy !== e[NC-1:0]) begin
        n_fail++;
        $display("FAIL sb_busy edge %0d: got %b expected %b",
                 edge_no, busy, e[NC-1:0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int t1;
    int t2;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_tick", int'(tick), 0);
    chk("reset_busy", int'(busy), 7);
    resetn = 1'b1;
    run = 1'b1;
    ch_en = '1;

    // default period 3: tick[0] on edges 4, 8, 12
    for (int e = 1; e <= 12; e++) begin
      cyc();
      chk($sformatf("t1_tick0_e%0d", e), int'(tick[0]), int'(e % 4 == 0));
      chk("t1_busy", int'(busy), 7);
    end

    // ch1 period 0 periodic: tick every enabled cycle
    wr(1, 0, 0);
    restart = 3'b010;
    cyc();
    chk("t2_restart_tick1", int'(tick[1]), 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_tick1", int'(tick[1]), 1);
    end

    // ch2 one-shot period 5: one tick 6 edges later, busy drops with it
    for (int r = 0; r < 2; r++) begin
      if (r == 0) wr(2, 5, 1);
      restart = 3'b100;
      cyc();
      for (int k = 1; k <= 6; k++) begin
        cyc();
        chk("t3_tick2", int'(tick[2]), int'(k == 6));
        chk("t3_busy2", int'(busy[2]), int'(k < 6));
      end
      for (int k = 0; k < 8; k++) begin
        cyc();
        chk("t3_expired_tick2", int'(tick[2]), 0);
        chk("t3_expired_busy2", int'(busy[2]), 0);
      end
    end

    // ch0 period 9, pause 20 cycles at count 4
    wr(0, 9, 0);
    restart = 3'b001;
    cyc();
    repeat (5) cyc();
    run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("t4_pause_tick", int'(tick), 0);
    end
    run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("t4_resume_tick0", int'(tick[0]), int'(k == 5));
    end

    // mid-count period write: this interval stays 10, next is 8
    t1 = -1;
    t2 = -1;
    for (int e = 1; e <= 20; e++) begin
      if (e == 3) wr(0, 7, 0);
      cyc();
      if (tick[0]) begin
        if (t1 < 0) t1 = e;
        else if (t2 < 0) t2 = e;
      end
    end
    chk("t6_first_tick", t1, 10);
    chk("t6_second_tick", t2, 18);

    // out-of-range channel write must change nothing
    wr(3, 1, 1);
    cyc();
    repeat (10) cyc();

    // restart on the terminal-count cycle suppresses the tick
    wr(2, 3, 0);
    restart = 3'b100;
    cyc();
    repeat (3) cyc();
    restart = 3'b100;
    cyc();
    chk("t5_restart_at_zero", int'(tick[2]), 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("t5_tick2", int'(tick[2]), int'(k == 4));
    end

    // asynchronous reset mid-count with tick[1] high
    chk("t6_pre_reset_tick1", int'(tick[1]), 1);
    #3;
    resetn = 1'b0;
    #1;
    chk("t6_async_tick", int'(tick), 0);
    chk("t6_async_busy", int'(busy), 7);
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      run = ($urandom % 8) != 0;
      ch_en = NC'($urandom | $urandom);
      for (int i = 0; i < NC; i++)
        restart[i] = ($urandom % 16) == 0;
      if (($urandom % 8) == 0)
        wr($urandom % 4, $urandom % 12, 1'($urandom));
      cyc();
    end

    @(posedge clk);
    #2;
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
